// File: rtl/instr_fetch_debug_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_debug_ctrl
//
// Debug controller that sits between a UART receiver and a simple pipelined
// core. Commands arrive one byte at a time:
//   'L' <N> <4*N bytes>  load N 32-bit words (MSB first) into instruction
//                        memory starting at byte address 0 (N = 0 means 256)
//   'R'                  run: advance the pipeline every cycle until 'H'
//                        arrives or the fetched instruction equals HALT_WORD
//   'S'                  advance the pipeline by exactly one cycle
//
// Byte interface: i_rx_valid is a single-cycle strobe with no back-pressure.
// A byte is consumed on the rising edge where i_rx_valid is high; the
// controller is always ready, so there is no ready signal.
//
// Ports
//   i_clk             clock, all state changes on the rising edge
//   i_rst             asynchronous active-low reset
//   i_rx_data         byte from the UART receiver
//   i_rx_valid        i_rx_data valid for this cycle only
//   i_instr           instruction currently fetched at the program counter
//   o_inst_mem_wr_en  one-cycle write strobe into instruction memory
//   o_inst_mem_addr   write byte address
//   o_inst_mem_data   write data
//   o_step            pipeline advance enable
//   o_busy            high whenever the FSM is not in IDLE
//   o_halted          one-cycle pulse when RUN ends on HALT_WORD
//   o_load_count      number of words written by the latest load
//   o_dbg_state       current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module instr_fetch_debug_ctrl #(
    parameter int unsigned      NBITS     = 32,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic [NBITS-1:0] i_instr,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_halted,
    output logic [8:0]       o_load_count,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_DATA = 3'd2,
        RUN       = 3'd3,
        STEP      = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

    state_t           r_state;
    logic [8:0]       r_count_n;   // words expected in this load, 1..256
    logic [1:0]       r_byte_idx;  // byte position inside the current word
    // Only the three earlier bytes of a word need holding: the fourth byte
    // is taken straight from i_rx_data on the cycle the word is written.
    logic [23:0]      r_asm;
    logic [NBITS-1:0] r_wr_addr;   // address the next word will be written to

    logic             r_wr_en;
    logic [NBITS-1:0] r_mem_addr;
    logic [NBITS-1:0] r_mem_data;
    logic             r_step;
    logic             r_busy;
    logic             r_halted;
    logic [8:0]       r_load_count;

    logic [31:0]      w_word;
    logic             w_is_halt_instr;
    logic             w_is_halt_cmd;
    logic [8:0]       w_next_count;

    assign w_word          = {r_asm, i_rx_data};
    assign w_is_halt_instr = (i_instr == HALT_WORD);
    assign w_is_halt_cmd   = i_rx_valid && (i_rx_data == CMD_HALT);
    assign w_next_count    = r_load_count + 9'd1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_count_n    <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_wr_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_step       <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_load_count <= '0;
        end else begin
            // Strobes default low; they are raised only on the cycle they fire.
            r_wr_en  <= 1'b0;
            r_halted <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state      <= LOAD_CNT;
                                r_busy       <= 1'b1;
                                r_load_count <= '0;
                            end
                            CMD_RUN: begin
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                                r_step  <= 1'b1;
                            end
                            CMD_STEP: begin
                                r_state <= STEP;
                                r_busy  <= 1'b1;
                                r_step  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        r_count_n  <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
                        r_byte_idx <= '0;
                        r_wr_addr  <= '0;
                        r_state    <= LOAD_DATA;
                    end
                end

                LOAD_DATA: begin
                    // Every byte here is data, including command codes.
                    if (i_rx_valid) begin
                        r_asm      <= w_word[23:0];
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wr_en      <= 1'b1;
                            r_mem_data   <= NBITS'(w_word);
                            r_mem_addr   <= r_wr_addr;
                            r_wr_addr    <= r_wr_addr + NBITS'(4);
                            r_load_count <= w_next_count;
                            if (w_next_count == r_count_n) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end

                RUN: begin
                    // o_step stays high through the cycle that sees the
                    // terminating condition and drops on the following edge.
                    if (w_is_halt_instr || w_is_halt_cmd) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_step   <= 1'b0;
                        r_halted <= w_is_halt_instr;
                    end
                end

                STEP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_step  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_step  <= 1'b0;
                end
            endcase
        end
    end

    assign o_inst_mem_wr_en = r_wr_en;
    assign o_inst_mem_addr  = r_mem_addr;
    assign o_inst_mem_data  = r_mem_data;
    assign o_step           = r_step;
    assign o_busy           = r_busy;
    assign o_halted         = r_halted;
    assign o_load_count     = r_load_count;
    assign o_dbg_state      = r_state;

endmodule
